// File: rtl/gpio_cmd_pkg.sv
// Shared definitions for the GPIO command initiator: opcodes, field layout,
// FSM state and phase encodings.
package gpio_cmd_pkg;

  localparam int GPIO_NB_COM  = 8;
  localparam int GPIO_NB_DATA = 24;
  localparam int GPIO_NB_INST = 32;
  localparam int GPIO_NB_BER  = 64;

  // GPIO word layout: cmd[31:24], enable[23], data[22:0]
  localparam int CMD_MSB = 31;
  localparam int CMD_LSB = 24;
  localparam int ENB_BIT = 23;

  localparam logic [7:0] OP_RESET    = 8'h01;
  localparam logic [7:0] OP_EN_TX    = 8'h02;
  localparam logic [7:0] OP_EN_RX    = 8'h03;
  localparam logic [7:0] OP_PH_SEL   = 8'h04;
  localparam logic [7:0] OP_RUN_MEM  = 8'h05;
  localparam logic [7:0] OP_RD_MEM   = 8'h06;
  localparam logic [7:0] OP_IS_FULL  = 8'h07;
  localparam logic [7:0] OP_BER_S_I  = 8'h08;
  localparam logic [7:0] OP_BER_S_Q  = 8'h09;
  localparam logic [7:0] OP_BER_E_I  = 8'h0A;
  localparam logic [7:0] OP_BER_E_Q  = 8'h0B;
  localparam logic [7:0] OP_BER_HIGH = 8'h0C;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ASSERT   = 2'd1,
    ST_DEASSERT = 2'd2,
    ST_RESP     = 2'd3
  } state_t;

  typedef enum logic {
    PH_LO = 1'b0,
    PH_HI = 1'b1
  } phase_t;

endpackage

// File: rtl/gpio_cmd_timer.sv
// Loadable down-counter shared by the ASSERT and DEASSERT phases;
// done_o is high while the count sits at zero.
module gpio_cmd_timer #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/gpio_cmd_master.sv
// GPIO command initiator: drives cmd/enable/data, waits, captures the reply,
// chains BER_HIGH for wide reads. Macro GPIO_CMD_CNT_EN enables o_txn_count.
module gpio_cmd_master
  import gpio_cmd_pkg::*;
#(
  parameter int NB_COM   = GPIO_NB_COM,
  parameter int NB_DATA  = GPIO_NB_DATA,
  parameter int NB_INST  = GPIO_NB_INST,
  parameter int NB_BER   = GPIO_NB_BER,
  parameter int ENB_HOLD = 4,
  parameter int RSP_WAIT = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic [NB_COM-1:0]   i_req_cmd,
  input  logic [NB_DATA-2:0]  i_req_data,
  input  logic                i_req_wide,
  output logic [NB_INST-1:0]  o_cmd_to_fr,
  input  logic [NB_INST-1:0]  i_data_from_fr,
  output logic                o_rsp_valid,
  output logic [NB_BER-1:0]   o_rsp_data,
  output logic                o_busy,
  output logic [15:0]         o_txn_count
);

  localparam int NB_PAY  = NB_DATA - 1;
  localparam int TMR_MAX = (ENB_HOLD > RSP_WAIT) ? ENB_HOLD : RSP_WAIT;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;
  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(ENB_HOLD - 1);
  localparam logic [TMR_W-1:0] WAIT_LOAD = TMR_W'(RSP_WAIT - 1);

  state_t              state_q, state_d;
  phase_t              phase_q, phase_d;
  logic [NB_COM-1:0]   cmd_q, cmd_d;
  logic [NB_PAY-1:0]   data_q, data_d;
  logic                wide_q, wide_d;
  logic [NB_INST-1:0]  lo_q, lo_d;
  logic [NB_BER-1:0]   rsp_q, rsp_d;

  logic                tmr_load;
  logic [TMR_W-1:0]    tmr_val;
  logic                tmr_done;
  logic                accept;

  assign accept = i_req_valid && (state_q == ST_IDLE);

  gpio_cmd_timer #(
    .W (TMR_W)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    cmd_d    = cmd_q;
    data_d   = data_q;
    wide_d   = wide_q;
    lo_d     = lo_q;
    rsp_d    = rsp_q;
    tmr_load = 1'b0;
    tmr_val  = HOLD_LOAD;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_ASSERT;
          phase_d  = PH_LO;
          cmd_d    = i_req_cmd;
          data_d   = i_req_data;
          wide_d   = i_req_wide;
          tmr_load = 1'b1;
          tmr_val  = HOLD_LOAD;
        end
      end

      ST_ASSERT: begin
        if (tmr_done) begin
          state_d  = ST_DEASSERT;
          tmr_load = 1'b1;
          tmr_val  = WAIT_LOAD;
        end
      end

      ST_DEASSERT: begin
        // Last DEASSERT edge: capture and decide whether a BER_HIGH follows
        if (tmr_done) begin
          if ((phase_q == PH_LO) && wide_q) begin
            lo_d     = i_data_from_fr;
            cmd_d    = NB_COM'(OP_BER_HIGH);
            data_d   = '0;
            phase_d  = PH_HI;
            state_d  = ST_ASSERT;
            tmr_load = 1'b1;
            tmr_val  = HOLD_LOAD;
          end else begin
            state_d = ST_RESP;
            if (phase_q == PH_HI) begin
              rsp_d = NB_BER'({i_data_from_fr, lo_q});
            end else begin
              rsp_d = NB_BER'(i_data_from_fr);
            end
          end
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      phase_q <= PH_LO;
      cmd_q   <= '0;
      data_q  <= '0;
      wide_q  <= 1'b0;
      lo_q    <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
      wide_q  <= wide_d;
      lo_q    <= lo_d;
      rsp_q   <= rsp_d;
    end
  end

  // Enable is decoded from the state register so reset drops it at once
  assign o_cmd_to_fr = {cmd_q, (state_q == ST_ASSERT), data_q};
  assign o_req_ready = (state_q == ST_IDLE);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_rsp_valid = (state_q == ST_RESP);
  assign o_rsp_data  = rsp_q;

`ifdef GPIO_CMD_CNT_EN
  logic [15:0] txn_cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      txn_cnt_q <= '0;
    end else if (state_q == ST_RESP) begin
      txn_cnt_q <= txn_cnt_q + 16'd1;
    end
  end

  assign o_txn_count = txn_cnt_q;
`else
  assign o_txn_count = '0;
`endif

endmodule

// File: tb/tb_gpio_cmd_master.sv
// Bench for gpio_cmd_master: vector table, hand-written reset/hold-valid
// sequences and randomized transactions against a transaction-level model.
module tb_gpio_cmd_master;

  localparam int EH  = 4;
  localparam int RW  = 4;
  localparam int SEG = EH + RW;
`ifdef GPIO_CMD_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [7:0]  i_req_cmd;
  logic [22:0] i_req_data;
  logic        i_req_wide;
  logic [31:0] o_cmd_to_fr;
  logic [31:0] i_data_from_fr;
  logic        o_rsp_valid;
  logic [63:0] o_rsp_data;
  logic        o_busy;
  logic [15:0] o_txn_count;

  gpio_cmd_master #(
    .ENB_HOLD (EH),
    .RSP_WAIT (RW)
  ) dut (
    .clock          (clk),
    .reset          (rst_n),
    .i_req_valid    (i_req_valid),
    .o_req_ready    (o_req_ready),
    .i_req_cmd      (i_req_cmd),
    .i_req_data     (i_req_data),
    .i_req_wide     (i_req_wide),
    .o_cmd_to_fr    (o_cmd_to_fr),
    .i_data_from_fr (i_data_from_fr),
    .o_rsp_valid    (o_rsp_valid),
    .o_rsp_data     (o_rsp_data),
    .o_busy         (o_busy),
    .o_txn_count    (o_txn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          txn_done = 0;
  logic [63:0] prev_rsp = '0;
  logic [31:0] rsp_lo_v = '0;
  logic [31:0] rsp_hi_v = '0;
  logic [31:0] mem [32];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // File-register responder: BER_HIGH returns the high word, RD_MEM reads memory
  function automatic logic [31:0] fr_word(input logic [7:0] c, input logic [22:0] d);
    if (c == 8'h0C) return rsp_hi_v;
    if (c == 8'h06) return mem[d[4:0]];
    return rsp_lo_v;
  endfunction

  always @(posedge clk) begin
    i_data_from_fr <= fr_word(o_cmd_to_fr[31:24], o_cmd_to_fr[22:0]);
  end

  // Enable must stay low at least RW cycles between rising edges
  logic en_prev = 1'b0;
  logic seen_rise = 1'b0;
  int   low_run = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      en_prev   <= 1'b0;
      seen_rise <= 1'b0;
      low_run   <= 0;
    end else begin
      if (o_cmd_to_fr[23] && !en_prev) begin
        if (seen_rise) check("en_low_gap", 64'(low_run >= RW), 64'd1);
        seen_rise <= 1'b1;
      end
      en_prev <= o_cmd_to_fr[23];
      low_run <= o_cmd_to_fr[23] ? 0 : low_run + 1;
    end
  end

  task automatic scramble_inputs();
    i_req_valid = 1'($urandom_range(0, 1));
    i_req_cmd   = 8'($urandom);
    i_req_data  = 23'($urandom);
    i_req_wide  = 1'($urandom_range(0, 1));
  endtask

  task automatic run_txn(input logic [7:0] cmd, input logic [22:0] data, input logic wide,
                         input logic [31:0] lo, input logic [31:0] hi, input logic [63:0] exp_rsp,
                         input bit hold_valid, input bit scramble, input string tag);
    int          waited;
    int          len;
    int          seg;
    int          off;
    logic [31:0] ew;
    logic [2:0]  es;
    logic [63:0] er;
    logic [15:0] ecnt;
    @(negedge clk);
    waited = 0;
    while (!o_req_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check({tag, ".ready_wait"}, 64'(o_req_ready), 64'd1);
    if (!o_req_ready) return;
    rsp_lo_v    = lo;
    rsp_hi_v    = hi;
    i_req_valid = 1'b1;
    i_req_cmd   = cmd;
    i_req_data  = data;
    i_req_wide  = wide;
    @(posedge clk);
    #1;
    if (scramble) scramble_inputs();
    else if (!hold_valid) i_req_valid = 1'b0;
    len = wide ? 2 * SEG + 1 : SEG + 1;
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      seg = (c - 1) / SEG;
      off = (c - 1) % SEG;
      if (c == len) begin
        ew = wide ? 32'h0C00_0000 : {cmd, 1'b0, data};
        es = 3'b110;
        er = exp_rsp;
      end else begin
        ew = (seg == 0) ? {cmd, (off < EH), data} : {8'h0C, (off < EH), 23'h0};
        es = 3'b010;
        er = prev_rsp;
      end
      check($sformatf("%s.word@%0d", tag, c), 64'(o_cmd_to_fr), 64'(ew));
      check($sformatf("%s.stat@%0d", tag, c), 64'({o_rsp_valid, o_busy, o_req_ready}), 64'(es));
      check($sformatf("%s.rsp@%0d", tag, c), o_rsp_data, er);
      if (c == len) begin
        ecnt = CNT_EN ? 16'(txn_done) : 16'h0;
        check({tag, ".txn_cnt"}, 64'(o_txn_count), 64'(ecnt));
        if (!hold_valid) i_req_valid = 1'b0;
      end else if (scramble) begin
        scramble_inputs();
      end
    end
    txn_done++;
    prev_rsp = exp_rsp;
    $display("txn %s cmd=%h data=%h wide=%0d rsp=%h exp=%h", tag, cmd, data, wide, o_rsp_data, exp_rsp);
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [22:0] data;
    logic        wide;
    logic [31:0] lo;
    logic [31:0] hi;
    logic [63:0] rsp;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  rc;
    logic [22:0] rd;
    logic        rwide;
    logic [31:0] rlo;
    logic [31:0] rhi;
    logic [63:0] rexp;
    bit          any_valid;

    tbl[0] = '{8'h02, 23'h000001, 1'b0, 32'h0000_0077, 32'h0,          64'h0000_0000_0000_0077};
    tbl[1] = '{8'h08, 23'h000000, 1'b1, 32'h0000_0123, 32'h0000_0004, 64'h0000_0004_0000_0123};
    tbl[2] = '{8'h07, 23'h000000, 1'b0, 32'h0000_0001, 32'h0,          64'h0000_0000_0000_0001};
    tbl[3] = '{8'h06, 23'h000010, 1'b0, 32'h0,          32'h0,          64'h0000_0000_CAFE_0010};
    tbl[4] = '{8'h06, 23'h00001F, 1'b0, 32'h0,          32'h0,          64'h0000_0000_CAFE_001F};
    tbl[5] = '{8'h01, 23'h7FFFFF, 1'b0, 32'hFFFF_FFFF, 32'h0,          64'h0000_0000_FFFF_FFFF};
    tbl[6] = '{8'h05, 23'h2AAAAA, 1'b1, 32'hDEAD_BEEF, 32'h8000_0001, 64'h8000_0001_DEAD_BEEF};

    for (int i = 0; i < 32; i++) mem[i] = 32'hCAFE_0000 | 32'(i);
    i_req_valid = 1'b0;
    i_req_cmd   = '0;
    i_req_data  = '0;
    i_req_wide  = 1'b0;
    rst_n       = 1'b0;
    repeat (3) @(negedge clk);
    check("por.word", 64'(o_cmd_to_fr), 64'h0);
    check("por.stat", 64'({o_rsp_valid, o_busy, o_req_ready}), 64'b001);
    check("por.rsp", o_rsp_data, 64'h0);
    check("por.cnt", 64'(o_txn_count), 64'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_txn(tbl[i].cmd, tbl[i].data, tbl[i].wide, tbl[i].lo, tbl[i].hi, tbl[i].rsp,
              1'b0, (i % 2) == 1, $sformatf("vec%0d", i));
    end

    // Reset in the middle of ASSERT
    @(negedge clk);
    i_req_valid = 1'b1;
    i_req_cmd   = 8'h03;
    i_req_data  = 23'h5;
    i_req_wide  = 1'b0;
    @(posedge clk);
    #1 i_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid.en_before", 64'(o_cmd_to_fr[23]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid.en_async", 64'(o_cmd_to_fr[23]), 64'd0);
    check("mid.stat_async", 64'({o_rsp_valid, o_busy, o_req_ready}), 64'b001);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    any_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (o_rsp_valid || !o_req_ready) any_valid = 1'b1;
    end
    check("mid.no_rsp_idle", 64'(any_valid), 64'd0);
    check("mid.word", 64'(o_cmd_to_fr), 64'h0);
    check("mid.rsp", o_rsp_data, 64'h0);
    check("mid.cnt", 64'(o_txn_count), 64'h0);
    txn_done = 0;
    prev_rsp = '0;

    // Valid held high across two IS_FULL transactions
    run_txn(8'h07, 23'h0, 1'b0, 32'h1, 32'h0, 64'h1, 1'b1, 1'b0, "hold0");
    check("hold.valid_in_resp", 64'(i_req_valid), 64'd1);
    run_txn(8'h07, 23'h0, 1'b0, 32'h1, 32'h0, 64'h1, 1'b0, 1'b0, "hold1");

    for (int n = 0; n < 40; n++) begin
      rc    = 8'($urandom_range(1, 12));
      rd    = 23'($urandom);
      rwide = 1'($urandom_range(0, 1));
      rlo   = $urandom;
      rhi   = $urandom;
      rsp_lo_v = rlo;
      rsp_hi_v = rhi;
      rexp  = rwide ? {fr_word(8'h0C, 23'h0), fr_word(rc, rd)} : {32'h0, fr_word(rc, rd)};
      run_txn(rc, rd, rwide, rlo, rhi, rexp, 1'b0, 1'b1, $sformatf("rnd%0d", n));
    end

    repeat (3) @(negedge clk);
    check("end.cnt", 64'(o_txn_count), CNT_EN ? 64'(16'(txn_done)) : 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gpio_cmd_master.md
Name: gpio_cmd_master

Overview:
- Initiator side of the 32-bit GPIO command protocol used between the micro and the file register (cmd[31:24], enable[23], data[22:0]).
- Accepts one request at a time from a local requester (test sequencer, or a bridge from the micro bus), then drives the command word and the enable pulse.
- After a fixed response wait, captures the returned word.
- For 64-bit BER counters it automatically issues the follow-up BER_HIGH command and returns the full 64-bit value.

Parameters:
- NB_COM, 8, command field width.
- NB_DATA, 24, data-plus-enable field width; enable is bit NB_DATA-1.
- NB_INST, 32, GPIO word width.
- NB_BER, 64, wide response width.
- ENB_HOLD, 4, cycles enable is held high; must be >= 1.
- RSP_WAIT, 4, cycles enable is held low before capture; must be >= 3, to cover the edge detect, read_flag and memory cycles.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- i_req_valid  in  1  request strobe.
- o_req_ready  out  1  high only in IDLE.
- i_req_cmd  in  8  opcode.
- i_req_data  in  23  payload placed in bits [22:0].
- i_req_wide  in  1  64-bit read; issue BER_HIGH after the first capture.
- o_cmd_to_fr  out  32  GPIO command word to the file register.
- i_data_from_fr  in  32  GPIO response word from the file register.
- o_rsp_valid  out  1  one-cycle response strobe.
- o_rsp_data  out  64  response; upper 32 bits are 0 when not wide.
- o_busy  out  1  high whenever not in IDLE.
- o_txn_count  out  16  transaction counter (see Optional Feature).

Behaviour:
- Reset (asynchronous assert, synchronous release): state=IDLE; o_cmd_to_fr=0 (enable low); o_rsp_valid=0; o_rsp_data=0; o_req_ready=1; o_busy=0; counters=0.
- Accept: a request is taken on a clock edge with i_req_valid&&o_req_ready. All request fields are latched at that edge, and later changes on the inputs are ignored.
- i_req_valid while busy: not accepted; no queueing.
- States:
  - IDLE: on accept, go to ASSERT with phase=LO.
  - ASSERT: o_cmd_to_fr = {cmd, 1'b1, data}. Lasts ENB_HOLD cycles, then DEASSERT.
  - DEASSERT: o_cmd_to_fr = {cmd, 1'b0, data}. cmd and data are kept stable. Lasts RSP_WAIT cycles. i_data_from_fr is captured on the last edge of this state.
  - CAPTURE decision, taken on that same edge:
    - phase=LO and wide: store the low word, load cmd=8'h0C, data=0, phase=HI, go to ASSERT.
    - Otherwise: go to RESP.
  - RESP: o_rsp_valid=1 for exactly one cycle. o_rsp_data = wide ? {hi, lo} : {32'h0, lo}. Then IDLE.
- Latency: with accept at edge k, enable is high in cycles k+1..k+ENB_HOLD.
  - Narrow: o_rsp_valid in cycle k+ENB_HOLD+RSP_WAIT+1 (k+9 with defaults).
  - Wide: o_rsp_valid in cycle k+2*(ENB_HOLD+RSP_WAIT)+1 (k+17 with defaults).
- Enable is always low for at least RSP_WAIT cycles between two rising edges. Back-to-back requests are therefore seen as separate edges.
- Reuse of the previous payload: o_cmd_to_fr keeps the last cmd/data with enable=0 in IDLE. Reset is the only path that clears it.
- Write-type commands (RESET, EN_TX, EN_RX, PH_SEL, RUN_MEM) use the same sequence. Their response is returned as captured, with no checking.
- i_req_wide is honoured for any opcode. The requester is responsible for using it only with the BER opcodes.
- o_rsp_data holds its value until the next RESP.
- Reset mid-operation: state returns to IDLE immediately, enable drops asynchronously, and no o_rsp_valid is issued.

Optional Feature:
- Macro: GPIO_CMD_CNT_EN.
- Defined: o_txn_count increments by 1 in each RESP cycle, wraps 16'hFFFF -> 0, and is cleared by reset.
- Undefined: o_txn_count is tied to 0 and no counter logic is synthesized.

Decomposition:
- Shared package gpio_cmd_pkg:
  - opcode localparams (RESET 8'h01 … BER_HIGH 8'h0C);
  - field widths and bit positions (cmd [31:24], enable bit 23);
  - state encoding IDLE/ASSERT/DEASSERT/RESP;
  - phase encoding LO/HI.
- Sub-module gpio_cmd_timer: loadable down-counter with a done flag. It is loaded with ENB_HOLD-1 or RSP_WAIT-1 and is shared by ASSERT and DEASSERT.

Test Plan:
1. Reset low mid-ASSERT (enable=1) -> o_cmd_to_fr[23]=0 immediately, state IDLE, o_req_ready=1, no o_rsp_valid.
2. Narrow request EN_TX, data=1, accepted at edge k -> o_cmd_to_fr=32'h02800001 in cycles k+1..k+4, then 32'h02000001 in k+5..k+8; o_rsp_valid only in k+9.
3. Wide BER_S_I with responder returning 32'h00000123 then 32'h00000004 -> second phase drives 32'h0C800000; o_rsp_data=64'h0000000400000123 at k+17.
4. IS_FULL with i_data_from_fr=1 at capture, and i_req_valid held high through the whole transaction -> exactly one response 64'h1; a second transaction is accepted only at the IDLE cycle after RESP.
5. RD_MEM, addr 15'h0010, responder model of the file register with a 1-cycle memory -> o_rsp_data equals the memory word at address 16. Enable stays low for >= 4 cycles between consecutive RD_MEM requests.
6. With GPIO_CMD_CNT_EN defined, 65537 transactions -> o_txn_count=1. Undefined -> o_txn_count=0 throughout.
